// File: rtl/load_use_hazard_ctl_pkg.sv
// load_use_hazard_ctl_pkg
//   Shared definitions for the ID-stage load-use hazard controller:
//   instruction field positions, register-index width, FSM state encodings,
//   the NOP encoding and a small decode helper.
package load_use_hazard_ctl_pkg;

  localparam int REG_ADDR_W = 5;

  // Instruction field positions (MIPS-style R/I formats)
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FROZEN = 2'd2
  } hz_state_t;

  // rt is a real source only for ALU-rt, store and compare-branch forms
  function automatic logic rt_is_source(input logic reg_dest,
                                        input logic mem_write,
                                        input logic branch);
    return reg_dest | mem_write | branch;
  endfunction

endpackage

// File: rtl/load_use_hazard_ctl_load_dest_history.sv
// load_dest_history
//   Two-entry shift register of load destination registers in flight.
//   Entry 0 is the instruction in EXE, entry 1 the one in MEM; 0 = no load.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   hold       freeze both entries (whole-pipeline freeze)
//   bubble     a NOP enters EXE this cycle instead of the ID instruction
//   load       ID instruction is a load
//   dest       load destination register of the ID instruction
//   lh_exe     destination of a load currently in EXE
//   lh_mem     destination of a load currently in MEM
module load_dest_history #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  bubble,
  input  logic                  load,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic [REG_ADDR_W-1:0] lh_exe,
  output logic [REG_ADDR_W-1:0] lh_mem
);

  logic [REG_ADDR_W-1:0] exe_reg;
  logic [REG_ADDR_W-1:0] mem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_reg <= '0;
      mem_reg <= '0;
    end else if (!hold) begin
      mem_reg <= exe_reg;
      // A bubbled load never reaches EXE, so it must not be recorded
      exe_reg <= (load && !bubble) ? dest : '0;
    end
  end

  assign lh_exe = exe_reg;
  assign lh_mem = mem_reg;

endmodule

// File: rtl/load_use_hazard_ctl.sv
// load_use_hazard_ctl
//   ID-stage hazard controller. Stalls IF/ID and bubbles ID/EXE on load-use
//   and branch-compare dependences and on the forwarding unit's freeze
//   request; an external freeze holds the whole pipeline and wins over any
//   hazard. Outputs are combinational (no added latency); STALL_ERR is sticky
//   once MAX_STALL consecutive stall cycles have occurred.
// Ports:
//   CLK, RESET       clock, asynchronous active-high reset
//   Instr            instruction in ID
//   MemRead          ID instruction is a load (dest = Instr[20:16])
//   RegDest          ID instruction reads rt as ALU source
//   MemWrite         ID instruction is a store (reads rt)
//   Branch           ID instruction is a compare-branch (reads rs, rt)
//   FWD_REQ_FREEZE   forwarding unit requests a one-cycle stall
//   EXT_FREEZE       external whole-pipeline freeze
//   STALL_IF         hold PC and IF/ID
//   BUBBLE_ID        load a NOP into ID/EXE
//   LOAD_HAZARD      the current bubble is caused by a load dependence
//   STALL_ERR        sticky stall-length error
// Optional feature (macro HAZARD_PERF_CNT_EN): adds PERF_LOAD_STALLS,
//   PERF_BR_STALLS and PERF_FREEZE_CYC cycle counters (32-bit, wrapping).
module load_use_hazard_ctl #(
  parameter int REG_ADDR_W    = load_use_hazard_ctl_pkg::REG_ADDR_W,
  parameter int BR_LOAD_STALL = 2,
  parameter int MAX_STALL     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic        MemRead,
  input  logic        RegDest,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        FWD_REQ_FREEZE,
  input  logic        EXT_FREEZE,
  output logic        STALL_IF,
  output logic        BUBBLE_ID,
  output logic        LOAD_HAZARD,
  output logic        STALL_ERR
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] PERF_LOAD_STALLS,
  output logic [31:0] PERF_BR_STALLS,
  output logic [31:0] PERF_FREEZE_CYC
`endif
);

  import load_use_hazard_ctl_pkg::*;

  localparam int CNT_W = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

  logic [REG_ADDR_W-1:0] src_rs;
  logic [REG_ADDR_W-1:0] src_rt;
  logic [REG_ADDR_W-1:0] lh_exe;
  logic [REG_ADDR_W-1:0] lh_mem;
  logic [REG_ADDR_W-1:0] lh [2];
  logic [1:0]            lh_match;
  logic                  nb_ld;
  logic                  br_ld0;
  logic                  br_ld1;
  logic [31:0]           stall_n;
  logic                  need_stall;
  logic                  bubble;
  logic                  err_now;
  logic [CNT_W-1:0]      cnt_inc;

  hz_state_t             state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  err_reg;

  // Opcode, rd, shamt and funct play no part in hazard detection
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[31:RS_HI+1], Instr[RD_HI:RD_LO], Instr[RD_LO-1:0]};

  assign src_rs = Instr[RS_HI:RS_LO];
  assign src_rt = rt_is_source(RegDest, MemWrite, Branch) ? Instr[RT_HI:RT_LO] : '0;

  load_dest_history #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hist (
    .clk    (CLK),
    .rst    (RESET),
    .hold   (EXT_FREEZE),
    .bubble (bubble),
    .load   (MemRead),
    .dest   (Instr[RT_HI:RT_LO]),
    .lh_exe (lh_exe),
    .lh_mem (lh_mem)
  );

  assign lh[0] = lh_exe;
  assign lh[1] = lh_mem;

  // An empty slot holds 0, which also makes register 0 never match
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      assign lh_match[gi] = (lh[gi] != '0) && ((src_rs == lh[gi]) || (src_rt == lh[gi]));
    end
  endgenerate

  assign nb_ld  = !Branch && lh_match[0];
  assign br_ld0 = Branch && lh_match[0];
  assign br_ld1 = Branch && lh_match[1];

  // Stall length required this cycle; re-evaluated every cycle, so a
  // branch-on-load naturally drains over BR_LOAD_STALL cycles as the load
  // moves from EXE to MEM.
  always_comb begin
    stall_n = '0;
    if (nb_ld || br_ld1 || FWD_REQ_FREEZE) stall_n = 32'd1;
    if (br_ld0 && (32'(BR_LOAD_STALL) > stall_n)) stall_n = 32'(BR_LOAD_STALL);
  end

  assign need_stall = (stall_n != '0);
  assign bubble     = !RESET && !EXT_FREEZE && need_stall;

  // Consecutive stall cycles including the current one
  assign cnt_inc = (cnt_reg >= CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
  assign err_now = bubble && (cnt_inc >= CNT_MAX);

  assign STALL_IF    = !RESET && (EXT_FREEZE || need_stall);
  assign BUBBLE_ID   = bubble;
  assign LOAD_HAZARD = bubble && (nb_ld || br_ld0 || br_ld1);
  assign STALL_ERR   = !RESET && (err_reg || err_now);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (err_now) err_reg <= 1'b1;
      case (state_reg)
        RUN: begin
          if (EXT_FREEZE) begin
            state_reg <= FROZEN;
          end else if (need_stall) begin
            state_reg <= STALL;
            cnt_reg   <= cnt_inc;
          end
        end
        STALL: begin
          if (EXT_FREEZE) begin
            state_reg <= FROZEN;
          end else if (!need_stall) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        FROZEN: begin
          // Release cycle is itself evaluated, so a pending hazard costs
          // exactly its normal number of bubbles
          if (!EXT_FREEZE) begin
            if (need_stall) begin
              state_reg <= STALL;
              cnt_reg   <= cnt_inc;
            end else begin
              state_reg <= RUN;
              cnt_reg   <= '0;
            end
          end
        end
        default: begin
          state_reg <= RUN;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_reg;
  logic [31:0] perf_br_reg;
  logic [31:0] perf_frz_reg;
  logic        br_cause;
  logic        load_cause;

  // A branch-on-load cycle is attributed to the branch counter only
  assign br_cause   = bubble && (br_ld0 || br_ld1);
  assign load_cause = LOAD_HAZARD && !br_cause;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      perf_load_reg <= '0;
      perf_br_reg   <= '0;
      perf_frz_reg  <= '0;
    end else begin
      if (load_cause) perf_load_reg <= perf_load_reg + 32'd1;
      if (br_cause)   perf_br_reg   <= perf_br_reg + 32'd1;
      if (EXT_FREEZE) perf_frz_reg  <= perf_frz_reg + 32'd1;
    end
  end

  assign PERF_LOAD_STALLS = perf_load_reg;
  assign PERF_BR_STALLS   = perf_br_reg;
  assign PERF_FREEZE_CYC  = perf_frz_reg;
`endif

endmodule
